// File: rtl/mxv_tx_pkg.sv
// Shared definitions for the matrix-vector engine load transmitter:
// state encodings, default sizes and the job-length helper.
package mxv_tx_pkg;

  localparam int MAX_N_DEF  = 8;
  localparam int ADDR_W_DEF = 7;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_LOAD_N  = 4'd1;
  localparam state_t S_PREP    = 4'd2;
  localparam state_t S_FETCH   = 4'd3;
  localparam state_t S_WAIT_RD = 4'd4;
  localparam state_t S_PRESENT = 4'd5;
  localparam state_t S_STOP    = 4'd6;
  localparam state_t S_COLLECT = 4'd7;
  localparam state_t S_DONE    = 4'd8;

  // Number of source words in one job: n*n matrix elements followed by n vector elements.
  function automatic int unsigned total_len(input int unsigned n);
    return n * n + n;
  endfunction

endpackage

// File: rtl/mxv_stream_tx_if.sv
// Load/result handshake between the transmitter (master) and the
// matrix-vector engine (slave).
interface mxv_stream_tx_if #(
  parameter int Size = 8
);
  logic [Size-1:0] N;
  logic            N_Valid;
  logic            Prep_Valid;
  logic            Data_Valid;
  logic [Size-1:0] Data;
  logic            Stop;
  logic            pop_outside;
  logic            send;
  logic [Size-1:0] result;

  modport master (
    output N, N_Valid, Prep_Valid, Data_Valid, Data, Stop,
    input  pop_outside, send, result
  );

  modport slave (
    input  N, N_Valid, Prep_Valid, Data_Valid, Data, Stop,
    output pop_outside, send, result
  );
endinterface

// File: rtl/mxv_tx_index_cnt.sv
// Up-counter with synchronous clear and a terminal flag that is high
// when the next increment would reach the limit.
module mxv_tx_index_cnt #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] count,
  output logic              term
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + ADDR_W'(1);
  end

  assign term = ((count + ADDR_W'(1)) == limit);

endmodule

// File: rtl/mxv_stream_tx.sv
// Host-side transmitter: fetches an n x n matrix and an n-vector from source
// memory, streams them to the engine, then collects n results.
// Optional watchdog enabled by defining MXV_TX_TIMEOUT_EN.
module mxv_stream_tx
  import mxv_tx_pkg::*;
#(
  parameter int Size    = 8,
  parameter int MAX_N   = MAX_N_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [Size-1:0]      n_cfg,
  output logic                 src_rd,
  output logic [ADDR_W-1:0]    src_addr,
  input  logic [Size-1:0]      src_data,
  mxv_stream_tx_if.master      eng,
  output logic                 res_valid,
  output logic [Size-1:0]      res_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  if (((1 << ADDR_W) < (MAX_N * MAX_N + MAX_N)) || (TIMEOUT < 1)) begin : g_bad_cfg
    $error("mxv_stream_tx: ADDR_W too small for MAX_N, or TIMEOUT < 1");
  end

  state_t            state;
  logic [Size-1:0]   n_reg;
  logic [Size-1:0]   data_reg;
  logic [ADDR_W-1:0] total;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] res_cnt;
  logic              idx_term;
  logic              res_term;
  logic              n_ok;
  logic              accept;
  logic              res_hit;
  logic              cnt_clr;
  logic              wd_fire;

  assign n_ok    = (n_cfg != '0) && (n_cfg <= Size'(MAX_N));
  assign accept  = (state == S_PRESENT) && eng.pop_outside;
  assign res_hit = (state == S_COLLECT) && eng.send;
  assign cnt_clr = (state == S_DONE) || wd_fire;

  mxv_tx_index_cnt #(.ADDR_W(ADDR_W)) u_idx_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (accept),
    .limit (total),
    .count (idx),
    .term  (idx_term)
  );

  mxv_tx_index_cnt #(.ADDR_W(ADDR_W)) u_res_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (res_hit),
    .limit (ADDR_W'(n_reg)),
    .count (res_cnt),
    .term  (res_term)
  );

`ifdef MXV_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            stall;

  // Any progress (accept, send) or leaving the waiting states restarts the count.
  assign stall   = ((state == S_PRESENT) && !eng.pop_outside) ||
                   ((state == S_COLLECT) && !eng.send);
  assign wd_fire = stall && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 wd_cnt <= '0;
    else if (!stall || wd_fire) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + WD_W'(1);
  end
`else
  assign wd_fire = 1'b0;
`endif

  // NOTE: datapath registers are reset too, so every output reads 0 the
  // moment reset asserts, including mid-job aborts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      n_reg     <= '0;
      total     <= '0;
      data_reg  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      err       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (n_ok) begin
              n_reg <= n_cfg;
              total <= ADDR_W'(total_len(32'(n_cfg)));
              state <= S_LOAD_N;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOAD_N:  state <= S_PREP;
        S_PREP:    state <= S_FETCH;
        S_FETCH:   state <= S_WAIT_RD;
        S_WAIT_RD: begin
          data_reg <= src_data;
          state    <= S_PRESENT;
        end
        S_PRESENT: begin
          if (eng.pop_outside) state <= idx_term ? S_STOP : S_FETCH;
        end
        S_STOP:    state <= S_COLLECT;
        S_COLLECT: begin
          if (eng.send) begin
            res_valid <= 1'b1;
            res_data  <= eng.result;
            if (res_term) state <= S_DONE;
          end
        end
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
      if (wd_fire) begin
        state <= S_IDLE;
        err   <= 1'b1;
      end
    end
  end

  // Strobes decode directly from state, so they drop together with it.
  assign eng.N          = n_reg;
  assign eng.N_Valid    = (state == S_LOAD_N);
  assign eng.Prep_Valid = (state == S_PREP);
  assign eng.Data_Valid = (state == S_PRESENT);
  assign eng.Data       = data_reg;
  assign eng.Stop       = (state == S_STOP);
  assign src_rd         = (state == S_FETCH);
  assign src_addr       = idx;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

endmodule

// File: doc/mxv_stream_tx.md
Name: mxv_stream_tx

Overview:
Host-side transmitter that drives the matrix-vector engine's load interface. On a start pulse it fetches an N x N matrix and then an N-entry vector from a synchronous source memory. It presents them to the engine using the engine's own handshake (N_Valid, Prep_Valid, Data_Valid, Stop; advance on pop_outside), then collects N results from the engine's send pulses. It sits between the host buffer and the engine top level.

Parameters:
Size, 8, data and result width in bits
MAX_N, 8, largest legal matrix dimension
ADDR_W, 7, source address width; must satisfy 2^ADDR_W >= MAX_N*MAX_N+MAX_N
TIMEOUT, 255, watchdog limit in cycles (used only with optional feature)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run a job; ignored unless busy=0
n_cfg  in  Size  matrix dimension for the job
src_rd  out  1  source read strobe
src_addr  out  ADDR_W  source read address
src_data  in  Size  source read data, valid the cycle after src_rd
N  out  Size  dimension to engine
N_Valid  out  1  one-cycle strobe qualifying N
Prep_Valid  out  1  one-cycle prepare strobe
Data_Valid  out  1  element valid to engine
Data  out  Size  element to engine
Stop  out  1  one-cycle end-of-load strobe
pop_outside  in  1  engine accepted current element
send  in  1  engine result strobe
result  in  Size  engine result, valid with send
res_valid  out  1  one-cycle strobe, res_data valid
res_data  out  Size  captured result
busy  out  1  job in progress
done  out  1  one-cycle job-complete strobe
err  out  1  one-cycle error strobe

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0. Index and result counters 0.
- FSM states: IDLE, LOAD_N, PREP, FETCH, WAIT_RD, PRESENT, STOP, COLLECT, DONE.
- IDLE:
  - start=1 with 1<=n_cfg<=MAX_N: latch n, total=n*n+n (ADDR_W bits, no overflow by construction), go to LOAD_N.
  - Illegal n_cfg (0 or >MAX_N): err=1 for one cycle, stay in IDLE.
- busy=1 in every state except IDLE. start while busy is ignored.
- LOAD_N: N=n, N_Valid=1 for exactly one cycle. N holds n until the next job. Next state PREP.
- PREP: Prep_Valid=1 for one cycle. Next state FETCH.
- FETCH: src_rd=1, src_addr=idx. Next state WAIT_RD.
- WAIT_RD: capture src_data into Data. Next state PRESENT.
- PRESENT:
  - Data_Valid=1 and Data held stable until pop_outside=1 is sampled.
  - On acceptance: idx increments. If the new idx equals total, go to STOP; otherwise go to FETCH.
  - Minimum 3 cycles per element.
  - pop_outside outside PRESENT is ignored.
- Element order: idx 0..n*n-1 are matrix elements, row-major; idx n*n..total-1 are vector elements.
- STOP: Stop=1 for one cycle. Next state COLLECT.
- COLLECT:
  - Each send=1 gives res_data=result and res_valid=1 on the next cycle; result counter increments.
  - When the counter reaches n, go to DONE.
  - send in any other state is dropped without error.
- DONE: done=1 for one cycle, counters cleared, return to IDLE.
- Simultaneous send and state exit: the send of the n-th result causes the exit; there is no extra capture.
- Reset mid-job: immediate abort. No done or err is issued.

Optional Feature:
MXV_TX_TIMEOUT_EN
- Defined: a watchdog counts cycles spent in PRESENT without pop_outside, or in COLLECT without send.
  - The count reaches TIMEOUT: err=1 for one cycle, all strobes dropped, go to IDLE, no done.
  - The watchdog clears on every accepted element, every send, and every state change.
- Undefined: no watchdog. The block waits indefinitely and err flags only illegal n_cfg.

Decomposition:
- Package mxv_tx_pkg holds:
  - the state enum
  - the MAX_N and ADDR_W defaults
  - the total-length helper function n*n+n
- One sub-module, mxv_tx_index_cnt: an ADDR_W counter with clear, increment, and a terminal flag (idx+1==limit). It is used for both the element index and the result count.

Test Plan:
- n_cfg=2, source [1,2,3,4,5,6], pop_outside tied 1 -> N_Valid once with N=2, Prep_Valid once, Data sequence 1,2,3,4,5,6, Stop once. Then send results 17,39 -> res_data 17 then 39 with res_valid pulses, done once, busy drops.
- n_cfg=3, pop_outside asserted only every 5th cycle -> Data stable while Data_Valid=1 and not accepted. Exactly 12 elements delivered, none duplicated.
- n_cfg=0, and separately n_cfg=9 -> err one cycle, busy stays 0, no N_Valid.
- start asserted again mid-PRESENT with n_cfg=4 -> ignored, original n=2 job completes unchanged.
- reset asserted during COLLECT after 1 of 2 results -> all outputs 0 immediately, no done. A fresh job afterwards runs correctly.
- With MXV_TX_TIMEOUT_EN and TIMEOUT=10: pop_outside held 0 in PRESENT -> err on cycle 10, return to IDLE, Data_Valid 0.
